// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared encodings for the lane tap judge
package tap_pkg;

  localparam logic [1:0] GRADE_NONE    = 2'd0;
  localparam logic [1:0] GRADE_GOOD    = 2'd1;
  localparam logic [1:0] GRADE_PERFECT = 2'd2;
  localparam logic [1:0] GRADE_MISS    = 2'd3;

  localparam logic [8:0] DEFAULT_KEY_CODE = 9'h029;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_JUDGED,
    S_LOCKOUT
  } tap_state_t;

endpackage

// File: rtl/tap_lockout_timer.sv
// rtl/tap_lockout_timer.sv - loadable down-counter with expire pulse and busy flag
module tap_lockout_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         expire
);

  logic [W-1:0] count;
  logic         active;

  // Active for load_val+1 cycles; expire marks the last of them.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - 1'b1;
    end
  end

  assign busy   = active;
  assign expire = active && (count == '0);

endmodule

// File: rtl/tap_judge.sv
// rtl/tap_judge.sv - grades key taps against the live enemy position for one lane
module tap_judge
  import tap_pkg::*;
#(
  parameter logic [8:0]  KEY_CODE       = DEFAULT_KEY_CODE,
  parameter logic [3:0]  PERFECT_POS    = 4'd1,
  parameter logic [3:0]  GOOD_LO        = 4'd1,
  parameter logic [3:0]  GOOD_HI        = 4'd3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd5_000_000,
  parameter int          COMBO_W        = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               ready,
  input  logic               keydown,
  input  logic [8:0]         last_change,
  input  logic [3:0]         pos,
  output logic               hit,
  output logic [1:0]         grade,
  output logic               whiff,
  output logic               damage,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic               busy
);

  tap_state_t         state, state_d;
  logic [3:0]         pos_q;
  logic               pending, pending_d;
  logic               hit_d, whiff_d, damage_d, tmr_load, tmr_expire;
  logic [1:0]         grade_d;
  logic [COMBO_W-1:0] combo_d, combo_inc, max_d;
  logic               tap, spawn, despawn, in_good;

  assign tap       = ready && keydown && (last_change == KEY_CODE);
  assign spawn     = (pos != 4'd0) && ((pos_q == 4'd0) || (pos > pos_q));
  assign despawn   = (pos_q != 4'd0) && (pos == 4'd0);
  assign in_good   = (pos >= GOOD_LO) && (pos <= GOOD_HI);
  assign combo_inc = (combo == {COMBO_W{1'b1}}) ? combo : combo + 1'b1;
  assign max_d     = (combo_d > max_combo) ? combo_d : max_combo;

  tap_lockout_timer #(.W(24)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!enable),
    .load     (tmr_load),
    .load_val (LOCKOUT_CYCLES - 24'd1),
    .busy     (busy),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      pos_q     <= 4'd0;
      pending   <= 1'b0;
      hit       <= 1'b0;
      whiff     <= 1'b0;
      damage    <= 1'b0;
      grade     <= GRADE_NONE;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      state     <= state_d;
      pos_q     <= pos;
      pending   <= pending_d;
      hit       <= hit_d;
      whiff     <= whiff_d;
      damage    <= damage_d;
      grade     <= grade_d;
      combo     <= combo_d;
      max_combo <= max_d;
    end
  end

  always_comb begin
    state_d   = state;
    pending_d = pending;
    hit_d     = 1'b0;
    whiff_d   = 1'b0;
    damage_d  = 1'b0;
    grade_d   = grade;
    combo_d   = combo;
    tmr_load  = 1'b0;
    if (!enable) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (spawn) state_d = S_ARMED;
        S_ARMED: begin
          if (despawn) begin
            state_d  = S_IDLE;
            damage_d = 1'b1;
            grade_d  = GRADE_MISS;
            combo_d  = '0;
          end else if (tap && (pos == PERFECT_POS)) begin
            state_d = S_JUDGED;
            hit_d   = 1'b1;
            grade_d = GRADE_PERFECT;
            combo_d = combo_inc;
          end else if (tap && in_good) begin
            state_d = S_JUDGED;
            hit_d   = 1'b1;
            grade_d = GRADE_GOOD;
            combo_d = combo_inc;
          end else if (tap) begin
            state_d   = S_LOCKOUT;
            whiff_d   = 1'b1;
            tmr_load  = 1'b1;
            pending_d = 1'b1;
          end
        end
        S_JUDGED: begin
          if (despawn)    state_d = S_IDLE;
          else if (spawn) state_d = S_ARMED;
        end
        S_LOCKOUT: begin
          // pending tracks whether the enemy on screen still owes a judgement
          if (despawn) begin
            damage_d = 1'b1;
            grade_d  = GRADE_MISS;
            combo_d  = '0;
          end
          pending_d = spawn || (pending && !despawn);
          if (tmr_expire)
            state_d = (pending_d && (pos != 4'd0)) ? S_ARMED : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
